ps2_rx_frame: RTL
=================

// Module: ps2_rx_frame
// PURPOSE
//  Parametrised PS/2 receiver that replaces the raw 11-bit shift register. Runs entirely on the
//  system clock and oversamples ps2_clk/ps2_data (synchronise, glitch-filter, detect falling edge).
//  Assembles start/data/parity/stop frames, checks parity, stop bit and inter-bit timeout, and
//  queues good bytes in a small FIFO for the keyboard decoder / snake control logic.
// PARAMETERS
//  DATA_BITS       8      payload bits per frame (LSB first); frame = DATA_BITS+3 bits
//  SYNC_STAGES     2      flip-flop synchroniser depth on ps2_clk and ps2_data (>=2)
//  FILTER_LEN      4      consecutive equal samples needed to accept a new ps2_clk level (>=1)
//  TIMEOUT_CYCLES  50000  max clk cycles between falling edges inside a frame (1 ms at 50 MHz)
//  FIFO_DEPTH      4      received-byte queue depth (power of 2, >=2)
//  ODD_PARITY      1      1: odd parity (PS/2 standard), 0: even parity
// PORTS
//  clk         in   1             system clock
//  reset       in   1             asynchronous, active-low reset
//  ps2_clk     in   1             raw PS/2 clock pin (asynchronous)
//  ps2_data    in   1             raw PS/2 data pin (asynchronous)
//  rd_en       in   1             pop FIFO head; ignored when rx_valid=0
//  rx_data     out  DATA_BITS     FIFO head byte; valid while rx_valid=1
//  rx_valid    out  1             FIFO not empty
//  frame_q     out  DATA_BITS+3   last complete frame: [MSB]=stop,[MSB-1]=parity,data,[0]=start
//  parity_err  out  1             1-cycle pulse: frame with bad parity dropped
//  frame_err   out  1             1-cycle pulse: bad stop bit or timeout, frame dropped
//  overflow    out  1             1-cycle pulse: good frame arrived with FIFO full, byte dropped
//  busy        out  1             1 while state != IDLE
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0, FIFO empty, state IDLE, filtered ps2_clk level = 1,
//    bit counter and timeout counter 0. Assertion mid-frame discards the partial frame.
//  - Input path: SYNC_STAGES flops per pin; filtered clk level changes only after FILTER_LEN equal
//    consecutive synchronised samples. fall = filtered level 1->0, one-cycle strobe. ps2_data is
//    sampled (synchronised value) in the fall cycle.
//  - FSM states IDLE, RECV:
//    IDLE: fall && data=0 -> RECV, bitcnt=1, clear shift reg. fall && data=1 -> stay IDLE, ignored.
//    RECV: each fall shifts data in at MSB side (frame bits arrive start first); bitcnt++;
//      timeout counter cleared on each fall, else increments; reaching TIMEOUT_CYCLES ->
//      frame_err pulse, IDLE, nothing pushed, frame_q unchanged.
//      On the fall that captures bit DATA_BITS+2 (stop): evaluate in that cycle, go IDLE, and
//      next cycle: frame_q updated (always, even on error);
//        stop=0 -> frame_err (takes priority over parity; only one error pulse per frame);
//        parity wrong -> parity_err; else push byte (or overflow pulse if FIFO full).
//  - Parity: ODD_PARITY=1 requires XOR(data,parity)=1; ODD_PARITY=0 requires 0.
//  - Latency: raw ps2_clk fall to fall strobe = SYNC_STAGES+FILTER_LEN cycles (+/-1);
//    stop-bit fall strobe to rx_valid=1 = 1 cycle.
//  - FIFO: first-word-fall-through; rx_data shows head combinationally from storage.
//    Push+pop same cycle when full: both happen, no overflow. Push+rd_en when empty:
//    push happens, rd_en ignored. rx_data holds last value when empty (0 after reset).
// STRUCTURE
//  - Shared package ps2_pkg: FSM state encoding (IDLE/RECV), PS/2 frame field index
//    constants (START/PARITY/STOP offsets relative to DATA_BITS), common scan codes (0xF0, 0xE0).
//  - One sub-module: ps2_byte_fifo (parametrised DEPTH/WIDTH synchronous FWFT FIFO,
//    full/empty, async active-low reset). Sync/filter/FSM/checker stay in this module.
// TESTING (clk 50 MHz, PS/2 bit period 4000 cycles, defaults unless stated)
//  1. Frame 0x1C, parity 0, stop 1 -> rx_valid=1, rx_data=0x1C, frame_q=11'b1_0_00011100_0; rd_en pops, rx_valid=0.
//  2. Frame 0xF0 with parity bit 0 (correct is 1) -> parity_err pulse, rx_valid stays 0, frame_q[9]=0.
//  3. Frame 0x5A with stop bit 0 -> frame_err pulse only (no parity_err), FIFO unchanged.
//  4. Send 5 bits then stop clocking for TIMEOUT_CYCLES+10 -> frame_err, busy=0; then good 0x5A -> rx_data=0x5A.
//  5. Send 0x01..0x05 without rd_en -> overflow pulse on 5th; pops return 0x01..0x04 in order; push+pop on full -> no overflow.
//  6. ps2_clk low glitch of FILTER_LEN-1 cycles in IDLE/RECV -> no bit sampled; reset=0 mid-frame -> outputs 0, next frame received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame field offsets and common scan codes.
package ps2_pkg;

   // Receiver state: waiting for a start bit, or collecting the rest of a frame
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } ps2_state_e;

   // Start bit always sits at bit 0 of an assembled frame
   localparam int START_IDX = 0;

   // Frequent scan codes seen by the keyboard decoder
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXTEND = 8'hE0;

   // Parity bit position in a frame carrying data_bits payload bits
   function automatic int parity_idx(input int data_bits);
      return data_bits + 1;
   endfunction

   // Stop bit position (frame MSB) in a frame carrying data_bits payload bits
   function automatic int stop_idx(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small first-word-fall-through FIFO for received bytes. The head entry is visible
// combinationally; when empty the output keeps showing the last byte that was popped.
module ps2_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] hold_q;
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one wrap bit so full and empty can be told apart
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

   // Storage, pointer update and capture of the last popped byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         hold_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            hold_q   <= mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver on the system clock: synchronises and glitch-filters the PS/2 pins,
// assembles start/data/parity/stop frames, checks them and queues good bytes.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4,
   parameter int ODD_PARITY     = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ps2_clk_i,
   input  logic                 ps2_data_i,
   input  logic                 rd_en_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   output logic [DATA_BITS+2:0] frame_q_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overflow_o,
   output logic                 busy_o
);

   localparam int FRAME_BITS = DATA_BITS + 3;
   localparam int PAR_IDX    = parity_idx(DATA_BITS);
   localparam int STOP_IDX   = stop_idx(DATA_BITS);
   localparam int FCW        = $clog2(FILTER_LEN + 1);
   localparam int BCW        = $clog2(FRAME_BITS + 1);
   localparam int TCW        = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_s;
   logic                   data_s;
   logic                   filt_q;
   logic [FCW-1:0]         fcnt_q;
   logic                   fall_q;

   ps2_state_e             state_q;
   logic [BCW-1:0]         bitcnt_q;
   logic [TCW-1:0]         tmo_q;
   logic [FRAME_BITS-2:0]  shift_q;
   logic [FRAME_BITS-1:0]  last_frame_q;
   logic                   parity_err_q;
   logic                   frame_err_q;
   logic                   overflow_q;

   logic [FRAME_BITS-1:0]  frame_next;
   logic                   is_stop_fall;
   logic                   stop_ok;
   logic                   parity_ok;
   logic                   push_req;
   logic                   fifo_full;
   logic                   fifo_empty;

   // Both pins idle high, so the synchronisers start at 1 to avoid a false fall after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      end
   end

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign data_s = data_sync_q[SYNC_STAGES-1];

   // Accept a new clock level only after FILTER_LEN consecutive differing samples; strobe on 1->0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b1;
         fcnt_q <= '0;
         fall_q <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (clk_s == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_q <= clk_s;
            fcnt_q <= '0;
            fall_q <= ~clk_s;
         end else begin
            fcnt_q <= fcnt_q + 1'b1;
         end
      end
   end

   // The frame as it looks once the current data sample is shifted in; only meaningful on the stop fall
   assign frame_next   = {data_s, shift_q};
   assign is_stop_fall = fall_q && (state_q == ST_RECV) && (bitcnt_q == BCW'(FRAME_BITS - 1));
   assign stop_ok      = frame_next[STOP_IDX];
   assign parity_ok    = ((^frame_next[PAR_IDX:START_IDX+1]) == (ODD_PARITY != 0));
   assign push_req     = is_stop_fall && stop_ok && parity_ok;

   // Frame assembly, timeout supervision and registered frame/error outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bitcnt_q     <= '0;
         tmo_q        <= '0;
         shift_q      <= '0;
         last_frame_q <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tmo_q <= '0;
               if (fall_q && !data_s) begin
                  // A cleared register already holds the start bit at its top position
                  state_q  <= ST_RECV;
                  bitcnt_q <= BCW'(1);
                  shift_q  <= '0;
               end
            end
            ST_RECV: begin
               if (fall_q) begin
                  tmo_q    <= '0;
                  shift_q  <= frame_next[FRAME_BITS-1:1];
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q == BCW'(FRAME_BITS - 1)) begin
                     state_q      <= ST_IDLE;
                     bitcnt_q     <= '0;
                     last_frame_q <= frame_next;
                     // Only one error per frame: a bad stop bit hides any parity problem
                     if (!stop_ok) begin
                        frame_err_q <= 1'b1;
                     end else if (!parity_ok) begin
                        parity_err_q <= 1'b1;
                     end else if (fifo_full && !rd_en_i) begin
                        overflow_q <= 1'b1;
                     end
                  end
               end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                  frame_err_q <= 1'b1;
                  state_q     <= ST_IDLE;
                  bitcnt_q    <= '0;
                  tmo_q       <= '0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   ps2_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_req),
      .pop_i   (rd_en_i),
      .data_i  (frame_next[DATA_BITS:1]),
      .data_o  (rx_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rx_valid_o   = !fifo_empty;
   assign frame_q_o    = last_frame_q;
   assign parity_err_o = parity_err_q;
   assign frame_err_o  = frame_err_q;
   assign overflow_o   = overflow_q;
   assign busy_o       = (state_q == ST_RECV);

endmodule
